ahb_m2s_mux_dp: RTL and testbench
=================================

Name: ahb_m2s_mux_dp

Overview:
Parametrised AHB master-to-slave multiplexer for an N-master multi-layer bus.
- Address-phase signals are routed combinationally from the master selected by the arbiter's HMASTER.
- Data-phase ownership is tracked internally by a register advanced on HREADY, so the arbiter no longer supplies a separate data-phase select.
- Sits between the arbiter/master ports and the shared slave-side bus.
- Adds invalid-select protection and a saturating select-error counter.

Parameters:
NUM_MASTERS, 4, number of master ports (1..16)
ADDR_W, 32, HADDR width
DATA_W, 32, HWDATA width (32/64/128)
MID_W, 4, HMASTER width; 2**MID_W >= NUM_MASTERS
HPROT_DEF, 4'b0011, HPROT driven when select is invalid
ERRCNT_W, 8, width of select-error counter

Ports:
HCLK  input  1  bus clock, rising edge
HRESET  input  1  asynchronous active-high reset
HADDR_M  input  NUM_MASTERS*ADDR_W  packed master addresses; master i at [i*ADDR_W +: ADDR_W]
HTRANS_M  input  NUM_MASTERS*2  packed HTRANS
HWRITE_M  input  NUM_MASTERS  packed HWRITE
HSIZE_M  input  NUM_MASTERS*3  packed HSIZE
HBURST_M  input  NUM_MASTERS*3  packed HBURST
HPROT_M  input  NUM_MASTERS*4  packed HPROT
HWDATA_M  input  NUM_MASTERS*DATA_W  packed write data
HMASTER  input  MID_W  address-phase owner from arbiter
HREADY  input  1  bus-wide transfer-complete
HADDR  output  ADDR_W  muxed address
HTRANS  output  2  muxed transfer type
HWRITE  output  1  muxed direction
HSIZE  output  3  muxed size
HBURST  output  3  muxed burst
HPROT  output  4  muxed protection
HWDATA  output  DATA_W  write data of data-phase owner
HMASTERD  output  MID_W  registered data-phase owner
DPHASE_ACT  output  1  registered: a NONSEQ/SEQ data phase is in progress
SEL_ERR_CNT  output  ERRCNT_W  saturating count of invalid-select address phases

Behaviour:
- Address phase is combinational, with zero latency from HMASTER.
- When HMASTER < NUM_MASTERS, all six address-phase outputs come from master[HMASTER].
- When HMASTER >= NUM_MASTERS, outputs are forced to: HADDR=0, HTRANS=IDLE(2'b00), HWRITE=0, HSIZE=0, HBURST=SINGLE(0), HPROT=HPROT_DEF.
- Data-phase registers, sampled on the rising HCLK edge only when HREADY=1:
  - HMASTERD <= HMASTER.
  - DPHASE_ACT <= (muxed HTRANS is NONSEQ or SEQ).
  - dwrite <= DPHASE_ACT_next & muxed HWRITE.
- When HREADY=0, all data-phase registers hold, so wait states extend the current data phase.
- HWDATA = HWDATA_M[HMASTERD] when dwrite=1 and HMASTERD < NUM_MASTERS; otherwise 0. It is combinational from the registers.
- Address-phase invalid select never produces an active data phase: forced IDLE gives DPHASE_ACT=0.
- SEL_ERR_CNT increments by 1 on each edge where HREADY=1, HMASTER >= NUM_MASTERS and the HMASTER input's HTRANS would otherwise be irrelevant. It holds at all-ones (saturates, never wraps).
- Handover:
  - When HMASTER changes with HREADY=1, the new master owns the address phase immediately.
  - The old master keeps HWDATA until the next HREADY=1 edge.
- Reset (asynchronous assert, synchronous-to-HCLK deassert handled externally): HMASTERD=0, DPHASE_ACT=0, dwrite=0 (hence HWDATA=0), SEL_ERR_CNT=0.
- Reset asserted mid-transfer clears the data phase immediately; no partial write data is forwarded.
- NUM_MASTERS=1: HMASTER is ignored except in the invalid check.

Optional Feature:
AHB_M2S_LOCK_EN
- Defined:
  - Adds input HLOCK_M [NUM_MASTERS] and outputs HMASTLOCK (combinational, HLOCK_M[HMASTER], 0 if invalid) and HMASTLOCKD (registered on HREADY=1, reset 0).
  - An invalid select while HMASTLOCKD=1 also increments SEL_ERR_CNT.
- Undefined: these ports are absent and there is no lock logic.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE, BUSY, NONSEQ, SEQ.
  - HBURST encodings: SINGLE..INCR16.
  - HSIZE encodings.
  - HPROT default constant.
- Sub-module ahb_dphase_reg contains HMASTERD/DPHASE_ACT/dwrite (plus the optional lock register) with the HREADY enable.
- The top level contains the packed-vector muxes and the error counter.

Test Plan:
- Reset, then HMASTER=2, master2 NONSEQ write to 0x1000, HREADY=1 -> HADDR=0x1000 same cycle; next cycle HMASTERD=2, DPHASE_ACT=1, HWDATA=HWDATA_M[2].
- Back-to-back handover: M0 NONSEQ write then HMASTER=1 NONSEQ read -> HWDATA shows M0 data while HADDR shows M1 address; following cycle HWDATA=0.
- Hold HREADY=0 three cycles after the M3 write address phase while HMASTER changes to 1 -> HMASTERD stays 3, HWDATA=HWDATA_M[3] throughout.
- HMASTER=7 with NUM_MASTERS=4 -> HTRANS=IDLE, HPROT=4'b0011, DPHASE_ACT=0 next cycle; 300 such HREADY cycles -> SEL_ERR_CNT=255 (held).
- Assert HRESET mid data phase (DPHASE_ACT=1) -> HWDATA=0, HMASTERD=0, SEL_ERR_CNT=0 without waiting for a clock edge.
- With AHB_M2S_LOCK_EN: HLOCK_M[1]=1, HMASTER=1, HREADY=1 -> HMASTLOCK=1 immediately, HMASTLOCKD=1 next edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// ============================================================================
// Module : ahb_pkg
// Brief  : Shared AHB encodings (HTRANS, HBURST, HSIZE) and default HPROT.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HWORD = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_128   = 3'd4,
        HSIZE_256   = 3'd5,
        HSIZE_512   = 3'd6,
        HSIZE_1024  = 3'd7
    } hsize_e;

    localparam logic [3:0] c_HPROT_DEF = 4'b0011;

    // NONSEQ and SEQ are the only transfer types that open a data phase
    function automatic logic trans_is_active(input logic [1:0] i_trans);
        return (i_trans == HTRANS_NONSEQ) || (i_trans == HTRANS_SEQ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_dphase_reg.sv
// ============================================================================
// Module : ahb_dphase_reg
// Brief  : Data-phase ownership registers, advanced only when HREADY is high.
//          Optional lock register enabled by AHB_M2S_LOCK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_dphase_reg #(
    parameter int MID_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hready,
    input  logic [MID_W-1:0] i_hmaster,
    input  logic             i_trans_act,
    input  logic             i_hwrite,
`ifdef AHB_M2S_LOCK_EN
    input  logic             i_hlock,
    output logic             o_hmastlockd,
`endif
    output logic [MID_W-1:0] o_hmasterd,
    output logic             o_dphase_act,
    output logic             o_dwrite
);

    logic [MID_W-1:0] r_hmasterd;
    logic             r_dphase_act;
    logic             r_dwrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hmasterd   <= '0;
            r_dphase_act <= 1'b0;
            r_dwrite     <= 1'b0;
        end else if (i_hready) begin
            r_hmasterd   <= i_hmaster;
            r_dphase_act <= i_trans_act;
            r_dwrite     <= i_trans_act & i_hwrite;
        end
    end

    assign o_hmasterd   = r_hmasterd;
    assign o_dphase_act = r_dphase_act;
    assign o_dwrite     = r_dwrite;

`ifdef AHB_M2S_LOCK_EN
    logic r_hmastlockd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hmastlockd <= 1'b0;
        end else if (i_hready) begin
            r_hmastlockd <= i_hlock;
        end
    end

    assign o_hmastlockd = r_hmastlockd;
`endif

endmodule

`default_nettype wire

// File: rtl/ahb_m2s_mux_dp.sv
// ============================================================================
// Module : ahb_m2s_mux_dp
// Brief  : N-master AHB master-to-slave mux with internal data-phase tracking,
//          invalid-select protection and saturating select-error counter.
//          Optional bus-lock routing enabled by AHB_M2S_LOCK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_m2s_mux_dp #(
    parameter int         NUM_MASTERS = 4,
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter int         MID_W       = 4,
    parameter logic [3:0] HPROT_DEF   = ahb_pkg::c_HPROT_DEF,
    parameter int         ERRCNT_W    = 8
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [NUM_MASTERS*ADDR_W-1:0] HADDR_M,
    input  logic [NUM_MASTERS*2-1:0]      HTRANS_M,
    input  logic [NUM_MASTERS-1:0]        HWRITE_M,
    input  logic [NUM_MASTERS*3-1:0]      HSIZE_M,
    input  logic [NUM_MASTERS*3-1:0]      HBURST_M,
    input  logic [NUM_MASTERS*4-1:0]      HPROT_M,
    input  logic [NUM_MASTERS*DATA_W-1:0] HWDATA_M,
    input  logic [MID_W-1:0]              HMASTER,
    input  logic                          HREADY,
`ifdef AHB_M2S_LOCK_EN
    input  logic [NUM_MASTERS-1:0]        HLOCK_M,
    output logic                          HMASTLOCK,
    output logic                          HMASTLOCKD,
`endif
    output logic [ADDR_W-1:0]             HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [3:0]                    HPROT,
    output logic [DATA_W-1:0]             HWDATA,
    output logic [MID_W-1:0]              HMASTERD,
    output logic                          DPHASE_ACT,
    output logic [ERRCNT_W-1:0]           SEL_ERR_CNT
);

    import ahb_pkg::*;

    logic                w_sel_valid;
    logic [ADDR_W-1:0]   w_haddr;
    logic [1:0]          w_htrans;
    logic                w_hwrite;
    logic [2:0]          w_hsize;
    logic [2:0]          w_hburst;
    logic [3:0]          w_hprot;
    logic                w_trans_act;
    logic [MID_W-1:0]    w_hmasterd;
    logic                w_dwrite;
    logic                w_hmasterd_valid;
    logic [DATA_W-1:0]   w_hwdata;
    logic                w_err_inc;
    logic [ERRCNT_W-1:0] r_sel_err_cnt;

    assign w_sel_valid      = (32'(HMASTER) < NUM_MASTERS);
    assign w_hmasterd_valid = (32'(w_hmasterd) < NUM_MASTERS);

    // Address phase: defaults cover the invalid-select case, the loop overrides on a match
    always_comb begin
        w_haddr  = '0;
        w_htrans = HTRANS_IDLE;
        w_hwrite = 1'b0;
        w_hsize  = 3'd0;
        w_hburst = HBURST_SINGLE;
        w_hprot  = HPROT_DEF;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (32'(HMASTER) == i) begin
                w_haddr  = HADDR_M[i*ADDR_W +: ADDR_W];
                w_htrans = HTRANS_M[i*2 +: 2];
                w_hwrite = HWRITE_M[i];
                w_hsize  = HSIZE_M[i*3 +: 3];
                w_hburst = HBURST_M[i*3 +: 3];
                w_hprot  = HPROT_M[i*4 +: 4];
            end
        end
    end

    assign w_trans_act = trans_is_active(w_htrans);

    assign HADDR  = w_haddr;
    assign HTRANS = w_htrans;
    assign HWRITE = w_hwrite;
    assign HSIZE  = w_hsize;
    assign HBURST = w_hburst;
    assign HPROT  = w_hprot;

`ifdef AHB_M2S_LOCK_EN
    logic w_hmastlock;
    logic w_hmastlockd;

    always_comb begin
        w_hmastlock = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (32'(HMASTER) == i) begin
                w_hmastlock = HLOCK_M[i];
            end
        end
    end

    assign HMASTLOCK  = w_hmastlock;
    assign HMASTLOCKD = w_hmastlockd;
`endif

    ahb_dphase_reg #(
        .MID_W        (MID_W)
    ) u_dphase_reg (
        .clk          (HCLK),
        .rst          (HRESET),
        .i_hready     (HREADY),
        .i_hmaster    (HMASTER),
        .i_trans_act  (w_trans_act),
        .i_hwrite     (w_hwrite),
`ifdef AHB_M2S_LOCK_EN
        .i_hlock      (w_hmastlock),
        .o_hmastlockd (w_hmastlockd),
`endif
        .o_hmasterd   (w_hmasterd),
        .o_dphase_act (DPHASE_ACT),
        .o_dwrite     (w_dwrite)
    );

    assign HMASTERD = w_hmasterd;

    // Write data follows the registered owner, so a handover keeps the old master's data
    always_comb begin
        w_hwdata = '0;
        if (w_dwrite && w_hmasterd_valid) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (32'(w_hmasterd) == i) begin
                    w_hwdata = HWDATA_M[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign HWDATA = w_hwdata;

`ifdef AHB_M2S_LOCK_EN
    assign w_err_inc = ~w_sel_valid & (HREADY | w_hmastlockd);
`else
    assign w_err_inc = ~w_sel_valid & HREADY;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_sel_err_cnt <= '0;
        end else if (w_err_inc && (r_sel_err_cnt != {ERRCNT_W{1'b1}})) begin
            r_sel_err_cnt <= r_sel_err_cnt + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign SEL_ERR_CNT = r_sel_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ahb_m2s_mux_dp.sv
// ============================================================================
// Module : tb_ahb_m2s_mux_dp
// Brief  : Self-checking bench: directed sequences, vector table, random vs model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ahb_m2s_mux_dp;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int EW = 8;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [NM*AW-1:0]  HADDR_M;
    logic [NM*2-1:0]   HTRANS_M;
    logic [NM-1:0]     HWRITE_M;
    logic [NM*3-1:0]   HSIZE_M;
    logic [NM*3-1:0]   HBURST_M;
    logic [NM*4-1:0]   HPROT_M;
    logic [NM*DW-1:0]  HWDATA_M;
    logic [MW-1:0]     HMASTER;
    logic              HREADY;
    logic [AW-1:0]     HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [DW-1:0]     HWDATA;
    logic [MW-1:0]     HMASTERD;
    logic              DPHASE_ACT;
    logic [EW-1:0]     SEL_ERR_CNT;
`ifdef AHB_M2S_LOCK_EN
    logic [NM-1:0]     HLOCK_M;
    logic              HMASTLOCK;
    logic              HMASTLOCKD;
`endif

    // Per-master stimulus, packed onto the DUT buses below
    logic [AW-1:0] m_addr  [NM];
    logic [1:0]    m_trans [NM];
    logic          m_wr    [NM];
    logic [2:0]    m_size  [NM];
    logic [2:0]    m_burst [NM];
    logic [3:0]    m_prot  [NM];
    logic [DW-1:0] m_wdata [NM];

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            HADDR_M[i*AW +: AW]  = m_addr[i];
            HTRANS_M[i*2 +: 2]   = m_trans[i];
            HWRITE_M[i]          = m_wr[i];
            HSIZE_M[i*3 +: 3]    = m_size[i];
            HBURST_M[i*3 +: 3]   = m_burst[i];
            HPROT_M[i*4 +: 4]    = m_prot[i];
            HWDATA_M[i*DW +: DW] = m_wdata[i];
        end
    end

    always #5 HCLK = ~HCLK;

    ahb_m2s_mux_dp #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MID_W       (MW),
        .HPROT_DEF   (4'b0011),
        .ERRCNT_W    (EW)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR_M     (HADDR_M),
        .HTRANS_M    (HTRANS_M),
        .HWRITE_M    (HWRITE_M),
        .HSIZE_M     (HSIZE_M),
        .HBURST_M    (HBURST_M),
        .HPROT_M     (HPROT_M),
        .HWDATA_M    (HWDATA_M),
        .HMASTER     (HMASTER),
        .HREADY      (HREADY),
`ifdef AHB_M2S_LOCK_EN
        .HLOCK_M     (HLOCK_M),
        .HMASTLOCK   (HMASTLOCK),
        .HMASTLOCKD  (HMASTLOCKD),
`endif
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HWDATA      (HWDATA),
        .HMASTERD    (HMASTERD),
        .DPHASE_ACT  (DPHASE_ACT),
        .SEL_ERR_CNT (SEL_ERR_CNT)
    );

    int unsigned n_err = 0;
    int unsigned n_chk = 0;

    // Reference model: who owns the data phase, whether it writes, error count
    int   md_owner;
    logic md_act;
    logic md_wr;
    int   md_cnt;
    logic md_lockd;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        md_owner = 0;
        md_act   = 1'b0;
        md_wr    = 1'b0;
        md_cnt   = 0;
        md_lockd = 1'b0;
    endtask

    // Advance model with the inputs present before the edge, then step one clock
    task automatic tick();
        int   hm;
        logic lk;
        hm = int'(HMASTER);
        if (hm >= NM && (HREADY || md_lockd))
            md_cnt = (md_cnt < 255) ? md_cnt + 1 : 255;
        if (HREADY) begin
            md_owner = hm;
            if (hm < NM) begin
                md_act = (m_trans[hm] == 2'b10) || (m_trans[hm] == 2'b11);
                md_wr  = md_act && m_wr[hm];
            end else begin
                md_act = 1'b0;
                md_wr  = 1'b0;
            end
            lk = 1'b0;
`ifdef AHB_M2S_LOCK_EN
            if (hm < NM) lk = HLOCK_M[hm];
`endif
            md_lockd = lk;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_aphase(input string tag);
        int hm;
        hm = int'(HMASTER);
        if (hm < NM) begin
            chk({tag, "_haddr"},  HADDR,  m_addr[hm]);
            chk({tag, "_htrans"}, HTRANS, m_trans[hm]);
            chk({tag, "_hwrite"}, HWRITE, m_wr[hm]);
            chk({tag, "_hsize"},  HSIZE,  m_size[hm]);
            chk({tag, "_hburst"}, HBURST, m_burst[hm]);
            chk({tag, "_hprot"},  HPROT,  m_prot[hm]);
        end else begin
            chk({tag, "_haddr"},  HADDR,  0);
            chk({tag, "_htrans"}, HTRANS, 0);
            chk({tag, "_hwrite"}, HWRITE, 0);
            chk({tag, "_hsize"},  HSIZE,  0);
            chk({tag, "_hburst"}, HBURST, 0);
            chk({tag, "_hprot"},  HPROT,  4'b0011);
        end
    endtask

    task automatic check_dphase(input string tag);
        logic [DW-1:0] exp_wd;
        exp_wd = (md_wr && md_owner < NM) ? m_wdata[md_owner] : '0;
        chk({tag, "_hmasterd"}, HMASTERD, md_owner[MW-1:0]);
        chk({tag, "_dact"},     DPHASE_ACT, md_act);
        chk({tag, "_hwdata"},   HWDATA, exp_wd);
        chk({tag, "_errcnt"},   SEL_ERR_CNT, md_cnt[EW-1:0]);
    endtask

    typedef struct {
        logic [MW-1:0] hm;
        logic [1:0]    tr;
        logic          wr;
        logic [AW-1:0] ad;
        logic [3:0]    pr;
        logic [1:0]    e_tr;
        logic [3:0]    e_pr;
        logic [AW-1:0] e_ad;
        logic          e_act;
        logic          e_wv;
    } vec_t;

    vec_t vt [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{4'd0,  2'b10, 1'b1, 32'h100, 4'hA, 2'b10, 4'hA, 32'h100, 1'b1, 1'b1};
        vt[1] = '{4'd1,  2'b11, 1'b0, 32'h204, 4'h5, 2'b11, 4'h5, 32'h204, 1'b1, 1'b0};
        vt[2] = '{4'd2,  2'b01, 1'b1, 32'h308, 4'hF, 2'b01, 4'hF, 32'h308, 1'b0, 1'b0};
        vt[3] = '{4'd3,  2'b00, 1'b1, 32'h40C, 4'h1, 2'b00, 4'h1, 32'h40C, 1'b0, 1'b0};
        vt[4] = '{4'd4,  2'b10, 1'b1, 32'h510, 4'hC, 2'b00, 4'h3, 32'h0,   1'b0, 1'b0};
        vt[5] = '{4'd15, 2'b11, 1'b1, 32'h614, 4'h0, 2'b00, 4'h3, 32'h0,   1'b0, 1'b0};
        vt[6] = '{4'd3,  2'b11, 1'b1, 32'h718, 4'h7, 2'b11, 4'h7, 32'h718, 1'b1, 1'b1};
        vt[7] = '{4'd1,  2'b10, 1'b1, 32'h81C, 4'h2, 2'b10, 4'h2, 32'h81C, 1'b1, 1'b1};

        for (int i = 0; i < NM; i++) begin
            m_addr[i]  = '0;
            m_trans[i] = 2'b00;
            m_wr[i]    = 1'b0;
            m_size[i]  = 3'd2;
            m_burst[i] = 3'd0;
            m_prot[i]  = 4'h0;
            m_wdata[i] = 32'h5A00_0000 + i;
        end
`ifdef AHB_M2S_LOCK_EN
        HLOCK_M = '0;
`endif
        HMASTER = '0;
        HREADY  = 1'b1;
        HRESET  = 1'b1;
        model_reset();
        #22;
        chk("rst_hmasterd", HMASTERD, 0);
        chk("rst_dact", DPHASE_ACT, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_errcnt", SEL_ERR_CNT, 0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Single write from master 2
        m_trans[2] = 2'b10; m_wr[2] = 1'b1; m_addr[2] = 32'h1000; m_wdata[2] = 32'hA2A2_0002;
        HMASTER = 4'd2;
        #1;
        chk("m2_haddr", HADDR, 32'h1000);
        chk("m2_htrans", HTRANS, 2'b10);
        tick();
        chk("m2_hmasterd", HMASTERD, 2);
        chk("m2_dact", DPHASE_ACT, 1);
        chk("m2_hwdata", HWDATA, 32'hA2A2_0002);

        // Handover: M0 write followed by M1 read
        m_trans[0] = 2'b10; m_wr[0] = 1'b1; m_addr[0] = 32'h2000; m_wdata[0] = 32'hD0D0_0000;
        HMASTER = 4'd0;
        tick();
        m_trans[1] = 2'b10; m_wr[1] = 1'b0; m_addr[1] = 32'h3000;
        HMASTER = 4'd1;
        #1;
        chk("ho_hwdata_old", HWDATA, 32'hD0D0_0000);
        chk("ho_haddr_new", HADDR, 32'h3000);
        tick();
        chk("ho_hwdata_read", HWDATA, 0);
        chk("ho_hmasterd", HMASTERD, 1);

        // Wait states after M3 write while the arbiter moves to M1
        m_trans[3] = 2'b10; m_wr[3] = 1'b1; m_addr[3] = 32'h4000; m_wdata[3] = 32'h3333_0003;
        HMASTER = 4'd3;
        tick();
        HMASTER = 4'd1;
        HREADY  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ws_hmasterd", HMASTERD, 3);
            chk("ws_hwdata", HWDATA, 32'h3333_0003);
        end
        HREADY = 1'b1;

        // Invalid select and counter saturation
        HMASTER = 4'd7;
        #1;
        chk("inv_htrans", HTRANS, 0);
        chk("inv_hprot", HPROT, 4'b0011);
        chk("inv_haddr", HADDR, 0);
        chk("inv_hwrite", HWRITE, 0);
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 1) begin
                chk("inv_dact", DPHASE_ACT, 0);
                chk("inv_cnt1", SEL_ERR_CNT, 1);
            end
            if (k == 254) chk("inv_cnt254", SEL_ERR_CNT, 254);
            if (k == 255) chk("inv_cnt255", SEL_ERR_CNT, 255);
        end
        chk("inv_cnt_sat", SEL_ERR_CNT, 255);

        // Asynchronous reset in the middle of an active write data phase
        HMASTER = 4'd2;
        tick();
        chk("ar_pre_dact", DPHASE_ACT, 1);
        chk("ar_pre_hwdata", HWDATA, 32'hA2A2_0002);
        #2;
        HRESET = 1'b1;
        #1;
        chk("ar_hwdata", HWDATA, 0);
        chk("ar_hmasterd", HMASTERD, 0);
        chk("ar_errcnt", SEL_ERR_CNT, 0);
        chk("ar_dact", DPHASE_ACT, 0);
        model_reset();
        @(negedge HCLK);
        HRESET = 1'b0;

        // Vector table
        for (int i = 0; i < NM; i++) m_wdata[i] = 32'hC0DE_0000 + i;
        for (int v = 0; v < 8; v++) begin
            if (int'(vt[v].hm) < NM) begin
                m_trans[vt[v].hm] = vt[v].tr;
                m_wr[vt[v].hm]    = vt[v].wr;
                m_addr[vt[v].hm]  = vt[v].ad;
                m_prot[vt[v].hm]  = vt[v].pr;
            end else begin
                for (int i = 0; i < NM; i++) begin
                    m_trans[i] = vt[v].tr; m_wr[i] = vt[v].wr;
                    m_addr[i]  = vt[v].ad; m_prot[i] = vt[v].pr;
                end
            end
            HMASTER = vt[v].hm;
            HREADY  = 1'b1;
            #1;
            chk($sformatf("vec%0d_htrans", v), HTRANS, vt[v].e_tr);
            chk($sformatf("vec%0d_hprot", v),  HPROT,  vt[v].e_pr);
            chk($sformatf("vec%0d_haddr", v),  HADDR,  vt[v].e_ad);
            tick();
            chk($sformatf("vec%0d_dact", v), DPHASE_ACT, vt[v].e_act);
            chk($sformatf("vec%0d_hwdata", v), HWDATA,
                vt[v].e_wv ? m_wdata[vt[v].hm[1:0]] : 32'h0);
        end

        // Randomized traffic against the model
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < NM; i++) begin
                m_addr[i]  = $urandom;
                m_trans[i] = 2'($urandom_range(0, 3));
                m_wr[i]    = 1'($urandom_range(0, 1));
                m_size[i]  = 3'($urandom_range(0, 7));
                m_burst[i] = 3'($urandom_range(0, 7));
                m_prot[i]  = 4'($urandom_range(0, 15));
                m_wdata[i] = $urandom;
            end
            HMASTER = 4'($urandom_range(0, 7));
            HREADY  = ($urandom_range(0, 3) != 0);
            #1;
            check_aphase("rnd");
            tick();
            check_dphase("rnd");
        end

`ifdef AHB_M2S_LOCK_EN
        HREADY     = 1'b1;
        HMASTER    = 4'd1;
        HLOCK_M    = 4'b0010;
        #1;
        chk("lock_comb", HMASTLOCK, 1);
        tick();
        chk("lock_reg", HMASTLOCKD, 1);
        HLOCK_M = '0;
        tick();
        chk("lock_release", HMASTLOCKD, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
